// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single-outstanding imem handshake and IF/ID register
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   pc_select, jump_target     redirect request and target address
//   stop                       load-use stall (freezes PC and IF/ID)
//   jump_reset                 flush: IF/ID becomes a bubble
//   imem_req, imem_addr        fetch request toward instruction memory
//   imem_ready                 memory accepts the request this cycle
//   imem_rvalid, imem_rdata    fetched instruction return
//   inst_D, pc_D, valid_D      IF/ID pipeline register
`timescale 1ns/1ps

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_select,
    input  logic [31:0] jump_target,
    input  logic        stop,
    input  logic        jump_reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D,
    output logic        valid_D
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        started;
    logic        accept;
    logic        deliver;
    logic [31:0] deliver_data;
    logic [31:0] pc_next;

    // started keeps imem_req low until the first edge after reset release
    assign imem_req  = started && (state == S_REQ);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;

    // A fetched word reaches IF/ID only when not stalled and not redirected
    assign deliver = !stop && !pc_select &&
                     (((state == S_WAIT) && imem_rvalid) || (state == S_HOLD));
    assign deliver_data = (state == S_HOLD) ? hold_buf : imem_rdata;

    always_comb begin
        pc_next = pc;
        if (pc_select) begin
            pc_next = jump_target & 32'hFFFF_FFFC;
        end else if (deliver) begin
            pc_next = pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_REQ;
            pc       <= RESET_PC & 32'hFFFF_FFFC;
            hold_buf <= 32'h0;
            started  <= 1'b0;
            inst_D   <= NOP_INST;
            pc_D     <= 32'h0;
            valid_D  <= 1'b0;
        end else begin
            started <= 1'b1;
            pc      <= pc_next;

            case (state)
                S_REQ: begin
                    // An accepted request under redirect must still be drained
                    if (accept) begin
                        state <= pc_select ? S_DROP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (pc_select) begin
                            state <= S_REQ;
                        end else if (stop) begin
                            hold_buf <= imem_rdata;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_REQ;
                        end
                    end else if (pc_select) begin
                        state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (pc_select || !stop) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase

            if (jump_reset) begin
                inst_D  <= NOP_INST;
                valid_D <= 1'b0;
            end else if (stop) begin
                inst_D  <= inst_D;
                valid_D <= valid_D;
            end else if (deliver) begin
                inst_D  <= deliver_data;
                pc_D    <= pc;
                valid_D <= 1'b1;
            end else begin
                inst_D  <= NOP_INST;
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013, meaning the bubble instruction placed in the IF/ID register (addi x0,x0,0).
REQ-003 SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- pc_select  input  1  redirect request; 1 = next PC is jump_target.
- jump_target  input  32  redirect address.
- stop  input  1  load-use stall; holds IF/ID and PC.
- jump_reset  input  1  flush; IF/ID becomes a bubble.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  fetched instruction.
- inst_D  output  32  IF/ID instruction.
- pc_D  output  32  IF/ID PC.
- valid_D  output  1  IF/ID holds a real instruction.

Function
REQ-004 SHALL keep at most one imem request outstanding; a request is accepted on a cycle with imem_req=1 and imem_ready=1.
REQ-005 SHALL hold the PC register with bits [1:0] always 0; redirects load {jump_target[31:2],2'b00}; increments are pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-006 SHALL implement FSM states REQ, WAIT, HOLD and DROP.
REQ-007 REQ: imem_req=1 and imem_addr=PC; on imem_ready go to WAIT; imem_addr may change while the request is not yet accepted.
REQ-008 WAIT: imem_req=0; on imem_rvalid with stop=0 load IF/ID with {imem_rdata, PC, valid 1}, set PC<=PC+4, go to REQ.
REQ-009 WAIT: on imem_rvalid with stop=1, capture imem_rdata into a 1-entry hold buffer and go to HOLD.
REQ-010 HOLD: imem_req=0; when stop=0, load IF/ID from the hold buffer with valid 1, set PC<=PC+4, go to REQ.
REQ-011 Redirect (pc_select=1): PC<=target. In REQ without imem_ready, stay REQ. In REQ with imem_ready, or in WAIT without imem_rvalid, go to DROP. In WAIT with imem_rvalid, discard the data and go to REQ. In HOLD, discard the buffer and go to REQ. In DROP, stay DROP.
REQ-012 DROP: imem_req=0; on imem_rvalid discard the data and go to REQ; no IF/ID load.
REQ-013 IF/ID update priority per cycle:
- jump_reset=1: inst_D<=NOP_INST, valid_D<=0; this overrides stop.
- else stop=1: hold all IF/ID fields.
- else a delivery per REQ-008/010: load it.
- otherwise: inst_D<=NOP_INST, valid_D<=0, pc_D holds.
REQ-014 stop=1 without a redirect SHALL freeze the PC; a redirect during stop SHALL still load the PC.
REQ-015 Fetch latency: with imem_ready and imem_rvalid each one cycle after the request, an instruction SHALL reach IF/ID 2 cycles after first request, then one instruction per 2 cycles.
REQ-016 All outputs SHALL be registered or decoded from state/PC only; no combinational path from imem_rdata to any output.

Reset
REQ-017 rst_n=0 SHALL immediately force PC=RESET_PC, state=REQ, hold buffer empty, inst_D=NOP_INST, pc_D=0, valid_D=0.
REQ-018 imem_req SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.
REQ-019 Reset asserted mid-transaction SHALL abandon the outstanding request; an imem_rvalid arriving after release without an accepted post-reset request SHALL be ignored.

Verification
REQ-020 Reset release, imem always ready, rvalid next cycle, rdata=addr -> imem_addr sequence 0,4,8; inst_D/pc_D = 0/0, 4/4, 8/8; valid_D=1 on delivery cycles and 0 between.
REQ-021 stop=1 for 3 cycles while rvalid arrives (rdata=32'h00A00093) -> IF/ID holds the prior value; one cycle after stop drops, inst_D=32'h00A00093 and PC advances by 4 once.
REQ-022 pc_select=1, jump_reset=1, jump_target=32'h0000_0103 in WAIT -> late rvalid discarded; next imem_addr=32'h0000_0100; inst_D=NOP_INST, valid_D=0.
REQ-023 jump_reset=1 and stop=1 together -> valid_D=0, inst_D=NOP_INST.
REQ-024 PC=32'hFFFF_FFFC fetch completes -> next imem_addr=32'h0000_0000.
REQ-025 rst_n pulled low in WAIT, stale rvalid after release -> ignored; first IF/ID load comes from the RESET_PC fetch.
